// File: rtl/pc_gen_pkg.sv
// Shared types and width helpers for the fetch PC generator.
// The checkpoint struct matches the default RAS depth.
package pc_gen_pkg;

    localparam int DEF_RAS_DEPTH = 8;
    localparam int DEF_PTR_W = $clog2(DEF_RAS_DEPTH);
    localparam int DEF_CNT_W = $clog2(DEF_RAS_DEPTH + 1);
    localparam int DEF_CKPT_W = DEF_CNT_W + DEF_PTR_W;

    typedef struct packed {
        logic [DEF_CNT_W-1:0] count;
        logic [DEF_PTR_W-1:0] tos;
    } ras_ckpt_t;

    typedef enum logic [2:0] {
        SEL_REDIRECT,
        SEL_HOLD,
        SEL_RAS,
        SEL_TARGET,
        SEL_SEQ
    } next_pc_sel_e;

endpackage

// File: rtl/pc_gen_ras_if.sv
// Fetch-side bundle between predictor/redirect logic and the PC generator.
// master drives prediction/redirect; slave is the PC generator.
interface pc_gen_ras_if
    import pc_gen_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int CKPT_W = DEF_CKPT_W
);
    logic            stall;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            pred_is_call;
    logic            pred_is_ret;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [CKPT_W-1:0] redirect_ckpt;
    logic [XLEN-1:0] pc;
    logic [CKPT_W-1:0] ras_ckpt;
    logic            ras_empty;

    modport master (
        output stall, pred_taken, pred_target,
        output pred_is_call, pred_is_ret,
        output redirect_valid, redirect_pc, redirect_ckpt,
        input  pc, ras_ckpt, ras_empty
    );

    modport slave (
        input  stall, pred_taken, pred_target,
        input  pred_is_call, pred_is_ret,
        input  redirect_valid, redirect_pc, redirect_ckpt,
        output pc, ras_ckpt, ras_empty
    );
endinterface

// File: rtl/pc_gen_ras_stack.sv
// Circular return-address stack with saturating count.
// Restore reloads pointer/count only; entries are never repaired.
module ras_stack #(
    parameter int XLEN = 64,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             replace,
    input  logic             restore,
    input  logic [CNT_W-1:0] restore_count,
    input  logic [PTR_W-1:0] restore_tos,
    input  logic [XLEN-1:0]  wdata,
    output logic [XLEN-1:0]  top,
    output logic [CNT_W-1:0] count,
    output logic [PTR_W-1:0] tos,
    output logic [CNT_W-1:0] nxt_count,
    output logic [PTR_W-1:0] nxt_tos
);

    logic [XLEN-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] tos_inc;
    logic             full;

    assign tos_inc = tos + PTR_W'(1);
    assign full = (count == CNT_W'(DEPTH));
    assign top = mem[tos];

    always_comb begin
        nxt_tos = tos;
        nxt_count = count;
        if (push) begin
            nxt_tos = tos_inc;
            if (!full) nxt_count = count + CNT_W'(1);
        end else if (pop && count != '0) begin
            nxt_tos = tos - PTR_W'(1);
            nxt_count = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tos <= '0;
            count <= '0;
        end else if (restore) begin
            tos <= restore_tos;
            count <= restore_count;
        end else begin
            tos <= nxt_tos;
            count <= nxt_count;
        end
    end

    // Storage has no reset; contents are meaningless until pushed.
    always_ff @(posedge clk) begin
        if (!restore) begin
            if (push) mem[tos_inc] <= wdata;
            else if (replace) mem[tos] <= wdata;
        end
    end

endmodule

// File: rtl/pc_gen_ras.sv
// Fetch PC register and next-PC priority mux with return-address prediction.
// ras_ckpt reports the stack state after this cycle's non-redirect update.
module pc_gen_ras
    import pc_gen_pkg::*;
#(
    parameter int XLEN = 64,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int INSTR_BYTES = 4,
    parameter int RAS_DEPTH = 8,
    localparam int PTR_W = $clog2(RAS_DEPTH),
    localparam int CNT_W = $clog2(RAS_DEPTH + 1),
    localparam int CKPT_W = CNT_W + PTR_W
) (
    input logic clk,
    input logic rst,
    pc_gen_ras_if.slave bus
);

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  nxt_pc;
    logic [XLEN-1:0]  seq_pc;
    logic [XLEN-1:0]  top;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] nxt_count;
    logic [PTR_W-1:0] tos;
    logic [PTR_W-1:0] nxt_tos;
    logic             nonempty;
    logic             push;
    logic             pop;
    logic             replace;
    next_pc_sel_e     sel;

    assign seq_pc = pc_q + XLEN'(INSTR_BYTES);
    assign nonempty = (count != '0);

    always_comb begin
        sel = SEL_SEQ;
        push = 1'b0;
        pop = 1'b0;
        replace = 1'b0;
        priority case (1'b1)
            bus.redirect_valid: sel = SEL_REDIRECT;
            bus.stall: sel = SEL_HOLD;
            bus.pred_taken && bus.pred_is_ret: begin
                sel = nonempty ? SEL_RAS : SEL_TARGET;
                // Call+return swaps the top entry; on an empty stack it pushes.
                if (bus.pred_is_call) begin
                    replace = nonempty;
                    push = !nonempty;
                end else begin
                    pop = nonempty;
                end
            end
            bus.pred_taken: begin
                sel = SEL_TARGET;
                push = bus.pred_is_call;
            end
            default: sel = SEL_SEQ;
        endcase
    end

    always_comb begin
        nxt_pc = seq_pc;
        case (sel)
            SEL_REDIRECT: nxt_pc = bus.redirect_pc;
            SEL_HOLD: nxt_pc = pc_q;
            SEL_RAS: nxt_pc = top;
            SEL_TARGET: nxt_pc = bus.pred_target;
            default: nxt_pc = seq_pc;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_q <= RESET_VECTOR;
        else pc_q <= nxt_pc;
    end

    ras_stack #(
        .XLEN (XLEN),
        .DEPTH(RAS_DEPTH)
    ) u_ras (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .pop          (pop),
        .replace      (replace),
        .restore      (bus.redirect_valid),
        .restore_count(bus.redirect_ckpt[CKPT_W-1 -: CNT_W]),
        .restore_tos  (bus.redirect_ckpt[PTR_W-1:0]),
        .wdata        (seq_pc),
        .top          (top),
        .count        (count),
        .tos          (tos),
        .nxt_count    (nxt_count),
        .nxt_tos      (nxt_tos)
    );

    assign bus.pc = pc_q;
    assign bus.ras_ckpt = {nxt_count, nxt_tos};
    assign bus.ras_empty = !nonempty;

    a_ckpt_legal: assert property (
        @(posedge clk) disable iff (rst)
        bus.redirect_valid |->
            bus.redirect_ckpt[CKPT_W-1 -: CNT_W] <= CNT_W'(RAS_DEPTH)
    );

endmodule

// File: tb/tb_pc_gen_ras.sv
// Directed bench for pc_gen_ras: driver queues expected values per cycle,
// a monitor samples outputs just before each rising edge and compares.
module tb_pc_gen_ras;
    import pc_gen_pkg::*;

    typedef struct {
        string       nm;
        logic [63:0] pc;
        logic [6:0]  ck;
        logic        emp;
        logic        cck;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    pc_gen_ras_if #(.XLEN(64), .CKPT_W(DEF_CKPT_W)) bus ();

    pc_gen_ras #(
        .XLEN        (64),
        .RESET_VECTOR(64'h1000),
        .INSTR_BYTES (4),
        .RAS_DEPTH   (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ck(input int c, input int t);
        ras_ckpt_t r;
        r.count = 4'(c);
        r.tos = 3'(t);
        return r;
    endfunction

    task automatic cyc(
        input string nm, input logic r, st, tk, cl, rt,
        input logic [63:0] tgt, input logic rv,
        input logic [63:0] rpc, input logic [6:0] rck,
        input logic [63:0] epc, input logic [6:0] eck,
        input logic emp, input logic cck
    );
        exp_t e;
        @(negedge clk);
        rst = r;
        bus.stall = st;
        bus.pred_taken = tk;
        bus.pred_is_call = cl;
        bus.pred_is_ret = rt;
        bus.pred_target = tgt;
        bus.redirect_valid = rv;
        bus.redirect_pc = rpc;
        bus.redirect_ckpt = rck;
        e.nm = nm;
        e.pc = epc;
        e.ck = eck;
        e.emp = emp;
        e.cck = cck;
        exp_q.push_back(e);
    endtask

    task automatic idle(input string nm, input logic [63:0] epc,
                        input logic [6:0] eck, input logic emp);
        cyc(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, epc, eck, emp, 1);
    endtask

    task automatic call(input string nm, input logic [63:0] tgt,
                        input logic [63:0] epc, input logic [6:0] eck,
                        input logic emp);
        cyc(nm, 0, 0, 1, 1, 0, tgt, 0, 0, 0, epc, eck, emp, 1);
    endtask

    task automatic ret(input string nm, input logic [63:0] tgt,
                       input logic [63:0] epc, input logic [6:0] eck,
                       input logic emp);
        cyc(nm, 0, 0, 1, 0, 1, tgt, 0, 0, 0, epc, eck, emp, 1);
    endtask

    task automatic swap(input string nm, input logic [63:0] tgt,
                        input logic [63:0] epc, input logic [6:0] eck,
                        input logic emp);
        cyc(nm, 0, 0, 1, 1, 1, tgt, 0, 0, 0, epc, eck, emp, 1);
    endtask

    task automatic redir(input string nm, input logic [63:0] rpc,
                         input logic [6:0] rck, input logic [63:0] epc,
                         input logic [6:0] eck, input logic emp);
        cyc(nm, 0, 0, 0, 0, 0, 0, 1, rpc, rck, epc, eck, emp, 1);
    endtask

    // Monitor: sample just before the rising edge so ras_ckpt reflects
    // the inputs of the cycle being checked.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.pc !== e.pc) begin
                    errors++;
                    $display("FAIL %s pc got %h want %h", e.nm, bus.pc, e.pc);
                end
                checks++;
                if (bus.ras_empty !== e.emp) begin
                    errors++;
                    $display("FAIL %s ras_empty got %b want %b",
                             e.nm, bus.ras_empty, e.emp);
                end
                if (e.cck) begin
                    checks++;
                    if (bus.ras_ckpt !== e.ck) begin
                        errors++;
                        $display("FAIL %s ras_ckpt got %h want %h",
                                 e.nm, bus.ras_ckpt, e.ck);
                    end
                end
            end
        end
    end

    initial begin
        bus.stall = 0;
        bus.pred_taken = 0;
        bus.pred_is_call = 0;
        bus.pred_is_ret = 0;
        bus.pred_target = '0;
        bus.redirect_valid = 0;
        bus.redirect_pc = '0;
        bus.redirect_ckpt = '0;

        cyc("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 64'h1000, ck(0, 0), 1, 1);
        idle("seq0", 64'h1000, ck(0, 0), 1);
        idle("seq1", 64'h1004, ck(0, 0), 1);
        idle("seq2", 64'h1008, ck(0, 0), 1);
        redir("go2000", 64'h2000, ck(0, 0), 64'h100C, ck(0, 0), 1);
        call("call", 64'h3000, 64'h2000, ck(1, 1), 1);
        ret("ret", 64'hBAD, 64'h3000, ck(0, 0), 0);
        redir("go100", 64'h100, ck(0, 0), 64'h2004, ck(0, 0), 1);

        for (int k = 1; k <= 9; k++)
            call("ovf_call", 64'((k + 1) * 256), 64'(k * 256),
                 ck(k > 8 ? 8 : k, k % 8), k == 1);
        for (int j = 1; j <= 8; j++)
            ret("ovf_ret", 64'hBAD0,
                j == 1 ? 64'hA00 : 64'(32'h904 - (j - 2) * 256),
                ck(8 - j, (9 - j) % 8), 0);
        ret("ovf_empty", 64'hDEAD0, 64'h204, ck(0, 1), 1);

        cyc("stall", 0, 1, 1, 1, 0, 64'h5000, 0, 0, 0,
            64'hDEAD0, ck(0, 1), 1, 1);
        cyc("stall_redir", 0, 1, 1, 0, 0, 64'h5000, 1, 64'h4000, ck(2, 5),
            64'hDEAD0, ck(0, 1), 1, 1);
        idle("post_redir", 64'h4000, ck(2, 5), 0);

        call("call_a", 64'h6000, 64'h4004, ck(3, 6), 0);
        call("call_b", 64'h7000, 64'h6000, ck(4, 7), 0);
        call("call_c", 64'h8000, 64'h7000, ck(5, 0), 0);
        redir("recover", 64'h9000, ck(3, 6), 64'h8000, ck(5, 0), 0);
        ret("ret_a", 64'hBAD, 64'h9000, ck(2, 5), 0);
        redir("go_top", 64'hFFFF_FFFF_FFFF_FFFC, ck(0, 0),
              64'h4008, ck(2, 5), 0);

        idle("wrap", 64'hFFFF_FFFF_FFFF_FFFC, ck(0, 0), 1);
        call("call_0", 64'h50, 64'h0, ck(1, 1), 1);
        swap("swap", 64'hBAD, 64'h50, ck(1, 1), 0);
        ret("ret_swap", 64'hBAD, 64'h4, ck(0, 0), 0);
        swap("swap_empty", 64'h70, 64'h54, ck(1, 1), 1);
        ret("ret_swap0", 64'hBAD, 64'h70, ck(0, 0), 0);
        cyc("call_nt", 0, 0, 0, 1, 1, 64'hBAD, 0, 0, 0,
            64'h58, ck(0, 0), 1, 1);
        idle("after_nt", 64'h5C, ck(0, 0), 1);
        cyc("mid_rst", 1, 0, 1, 1, 0, 64'h700, 0, 0, 0,
            64'h1000, ck(0, 0), 1, 0);
        idle("rst_rel", 64'h1000, ck(0, 0), 1);
        idle("rst_seq", 64'h1004, ck(0, 0), 1);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_gen_ras.md
Name: pc_gen_ras

Overview:
- Parametrised fetch-stage PC generator for the pipelined core, replacing the fixed 64-bit PC register.
- Adds a configurable reset vector, instruction stride and XLEN.
- Adds a circular return-address stack (RAS) for call/return prediction, with checkpoint restore on misprediction redirects.
- Sits between the fetch predictor/predecoder and the instruction memory address port.

Parameters:
- XLEN, 64: width of PC and all address ports.
- RESET_VECTOR, 0: PC value loaded on reset.
- INSTR_BYTES, 4: sequential increment and call return-address offset.
- RAS_DEPTH, 8: number of RAS entries; must be a power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- stall  in  1  hold PC and RAS (fetch/decode hazard).
- pred_taken  in  1  predictor says the current fetch is a taken control transfer.
- pred_target  in  XLEN  predicted target for taken non-return transfers.
- pred_is_call  in  1  current fetch is a call; qualified by pred_taken.
- pred_is_ret  in  1  current fetch is a return; qualified by pred_taken.
- redirect_valid  in  1  execute-stage misprediction correction.
- redirect_pc  in  XLEN  corrected PC.
- redirect_ckpt  in  CKPT_W  RAS checkpoint carried by the mispredicted instruction.
- pc  out  XLEN  current fetch PC.
- ras_ckpt  out  CKPT_W  post-update RAS checkpoint for the current fetch; the pipeline carries it downstream.
- ras_empty  out  1  RAS count is 0.

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk.
- Widths:
  - PTR_W = clog2(RAS_DEPTH).
  - CNT_W = clog2(RAS_DEPTH+1).
  - CKPT_W = CNT_W+PTR_W; checkpoint layout is {count, tos}.
  - All PC arithmetic is modulo 2^XLEN, so pc+INSTR_BYTES wraps silently.
- Reset:
  - pc = RESET_VECTOR.
  - tos = 0, count = 0, so ras_empty = 1.
  - RAS entry contents are don't-care and are not required to be cleared.
  - Reset asserted mid-operation overrides everything on the same cycle.
- Next-PC priority, evaluated each cycle:
  1. redirect_valid: pc <= redirect_pc; {count, tos} <= redirect_ckpt; no push or pop.
  2. stall: pc, tos, count and RAS entries all held.
  3. pred_taken with pred_is_ret: pc <= RAS[tos] if count>0, otherwise pc <= pred_target. Pop means tos-1 (mod RAS_DEPTH) and count-1, only when count>0.
  4. pred_taken with pred_is_call (and not a return): push pc+INSTR_BYTES, then pc <= pred_target.
  5. pred_taken only: pc <= pred_target.
  6. Otherwise: pc <= pc+INSTR_BYTES.
- Push: tos <= tos+1 (mod RAS_DEPTH); write RAS[tos+1]; count <= min(count+1, RAS_DEPTH).
- Overflow: a push when count==RAS_DEPTH overwrites the oldest entry (circular wrap) and count stays saturated.
- Call and return together (coroutine swap):
  - Target is RAS[tos] if count>0, else pred_target.
  - The top entry is replaced in place by pc+INSTR_BYTES; tos and count are unchanged.
  - If count==0 it behaves as a plain push.
- pred_is_call or pred_is_ret without pred_taken: ignored.
- Latency: pc updates one cycle after its inputs are sampled; RAS[tos] is read combinationally in the same cycle.
- ras_ckpt is combinational and equals the {count, tos} the RAS will hold after this cycle's update if not redirected. During stall it equals the current state.
- Recovery scope: restore is pointer/count only. Entries overwritten by wrong-path pushes are not repaired; this is an accepted imprecision.
- Redirect and stall in the same cycle: redirect wins.
- Redirect with a checkpoint count greater than RAS_DEPTH: illegal; assertion only.

Decomposition:
- Package pc_gen_pkg holds:
  - ras_ckpt_t packed struct {count, tos}.
  - Width helper localparams.
  - Enum next_pc_sel_e {SEL_REDIRECT, SEL_HOLD, SEL_RAS, SEL_TARGET, SEL_SEQ} for debug visibility.
- One sub-module, ras_stack: storage array, tos and count, with push/pop/replace/restore controls and top-of-stack output.
- pc_gen_ras keeps the PC register and the priority mux.

Test Plan:
- Reset and sequential fetch: RESET_VECTOR=0x1000, release rst, no inputs → pc = 0x1000, 0x1004, 0x1008; ras_empty=1.
- Call then return: at pc=0x2000, call (pred_taken=1, pred_is_call=1, pred_target=0x3000) → pc=0x3000, ras_ckpt={1,1}. Then return → pc=0x2004, ras_empty=1.
- Overflow: 9 nested calls with RAS_DEPTH=8, from pcs 0x100, 0x200, …, 0x900 → count saturates at 8. Then 8 returns yield 0x904 down to 0x204. A 9th return with pred_target=0xDEAD0 → pc=0xDEAD0.
- Stall against redirect priority: stall=1 with pred_taken → pc and ras_ckpt unchanged. Then stall=1 with redirect_valid=1, redirect_pc=0x4000, redirect_ckpt={2,5} → pc=0x4000, ras_ckpt={2,5}.
- Misprediction recovery: push A and B, capture ckpt after A, push wrong-path C, redirect with A's ckpt → the next return yields A+4.
- Wrap and call+return swap: pc=0xFFFF_FFFF_FFFF_FFFC sequential → pc=0. A call+return with count=1 swaps the top entry, leaves count=1, and the target is the old top.
